dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder (target side) of the CPU load/store bus. Accepts one request at a time
//  over a valid/ready handshake, inserts programmable wait states, then performs the word access
//  with byte-lane strobes and returns read data or an error on a response channel. Sits between
//  the CPU's memory-request port and the word-organised storage array.
// PARAMETERS
//  DEPTH_WORDS  64  number of 32-bit words; legal word index 0..DEPTH_WORDS-1
//  WAIT_CYCLES  2   wait states between accept and access (0..15)
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   asynchronous, active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept (high only in IDLE)
//  req_we     in   1   1 = store, 0 = load
//  req_addr   in   32  byte address; bits [1:0] must be 00
//  req_be     in   4   store byte strobes; be[3] = bits 31:24 (big-endian lane 0); ignored on load
//  req_wdata  in   32  store data
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   CPU takes response
//  rsp_rdata  out  32  load data (0 for stores and errors)
//  rsp_err    out  1   1 = misaligned, out-of-range or empty-strobe store
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE, req_ready=1 after release, rsp_valid=0, rsp_rdata=0,
//    rsp_err=0, wait counter=0, latched request cleared. Storage array NOT reset.
//  - FSM states: IDLE, WAIT, ACCESS, RESP.
//  - IDLE: req_ready=1. On req_valid&&req_ready edge latch we/addr/be/wdata.
//    Error if addr[1:0]!=0, addr[31:2]>=DEPTH_WORDS, or (we && be==0) -> go RESP, err=1,
//    rdata=0, no array write. Else WAIT_CYCLES==0 -> ACCESS; else load counter, -> WAIT.
//  - WAIT: counter decrements each cycle; at 1 -> ACCESS. Exactly WAIT_CYCLES cycles in WAIT.
//  - ACCESS (one cycle): store writes only lanes with be=1, other lanes unchanged; load captures
//    full word into rsp_rdata. -> RESP.
//  - RESP: rsp_valid=1, rdata/err stable until handshake. rsp_valid&&rsp_ready -> IDLE,
//    rsp_valid drops next cycle; rsp_rdata/rsp_err return to 0.
//  - Latency: accept edge to rsp_valid high = WAIT_CYCLES+2 cycles for legal access, 1 cycle
//    for error. Min issue interval = WAIT_CYCLES+3 cycles (no accept in RESP, even if rsp_ready).
//  - req_valid held while req_ready=0: ignored, no side effects.
//  - Reset mid-operation: any un-ACCESSed store is discarded, array unchanged; a store whose
//    ACCESS edge already occurred stays written. Pending response dropped.
//  - Store then load same word in consecutive transactions returns newly written data.
//  - Address arithmetic: word index = addr[31:2]; range compare at full 30-bit width (no wrap).
// STRUCTURE
//  - Shared package: state enum (IDLE/WAIT/ACCESS/RESP), lane mapping constants
//    (LANE0=31:24..LANE3=7:0), error-cause localparams.
//  - One sub-module: dmem_array (DEPTH_WORDS x 32, sync write with 4 byte enables, comb read);
//    FSM, counter and range/alignment check stay in this module.
// TESTING
//  1. Reset: hold reset=0 mid-WAIT -> req_ready=1, rsp_valid=0, rsp_err=0; target word unchanged.
//  2. Store addr 0x10, be=1111, data 0xDEADBEEF, then load 0x10 -> rdata 0xDEADBEEF, err=0,
//     rsp_valid 4 cycles after each accept (WAIT_CYCLES=2).
//  3. Byte store addr 0x10, be=0100, data 0x00AA0000 over 0xDEADBEEF -> load returns 0xDEAABEEF.
//  4. Load addr 0x13 and addr 0x100 (DEPTH 64) -> rsp_err=1, rdata=0, 1 cycle latency; array intact.
//  5. Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rdata stable; req_ready=0; new
//     req_valid ignored until IDLE.
//  6. WAIT_CYCLES=0 build: store/load 0x3C with 0x12345678 -> response 2 cycles after accept.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: FSM state enum, byte-lane map (be[3] -> bits 31:24) and error causes for the responder
package dmem_responder_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
  localparam int LANE0_LSB = 24;
  localparam int LANE1_LSB = 16;
  localparam int LANE2_LSB = 8;
  localparam int LANE3_LSB = 0;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_STRB = 2'd3;
  function automatic logic [1:0] err_cause(input logic we, input logic [31:0] addr, input logic [3:0] be,
                                           input int unsigned depth);
    return addr[1:0] != 2'b00 ? ERR_ALIGN :
           {2'b00, addr[31:2]} >= depth ? ERR_RANGE :
           (we && be == 4'h0) ? ERR_STRB : ERR_NONE;
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: CPU load/store bus; master drives req_valid/we/addr/be/wdata and rsp_ready, slave drives req_ready and rsp_valid/rdata/err
interface dmem_responder_if;
  logic req_valid, req_ready, req_we;
  logic [31:0] req_addr;
  logic [3:0] req_be;
  logic [31:0] req_wdata;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  modport master(output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
                 input req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave(input req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
                output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/dmem_array.sv
// dmem_array: DEPTH_WORDS x 32 storage, unreset; in clk, we, be (byte strobes), idx, wdata; out rdata (combinational read)
module dmem_array import dmem_responder_pkg::*; #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk)
    if (we) begin
      if (be[3]) mem[idx][LANE0_LSB +: 8] <= wdata[LANE0_LSB +: 8];
      if (be[2]) mem[idx][LANE1_LSB +: 8] <= wdata[LANE1_LSB +: 8];
      if (be[1]) mem[idx][LANE2_LSB +: 8] <= wdata[LANE2_LSB +: 8];
      if (be[0]) mem[idx][LANE3_LSB +: 8] <= wdata[LANE3_LSB +: 8];
    end
  assign rdata = mem[idx];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory target; in clk, reset (async active-low), bus (slave modport: req/rsp valid-ready channels); wait states then strobed word access
module dmem_responder import dmem_responder_pkg::*; #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic            clk,
  input logic            reset,
  dmem_responder_if.slave bus
);
  localparam int unsigned AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  state_t state, state_n;
  logic [3:0] cnt;
  logic lat_we, acc, bad, arr_we;
  logic [AW-1:0] lat_idx;
  logic [3:0] lat_be;
  logic [31:0] lat_wdata, arr_rdata;
  assign acc = bus.req_valid && bus.req_ready;
  assign bad = err_cause(bus.req_we, bus.req_addr, bus.req_be, DEPTH_WORDS) != ERR_NONE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (acc) state_n = bad ? RESP : (WAIT_CYCLES == 0 ? ACCESS : WAIT);
      WAIT:    if (cnt == 4'd1) state_n = ACCESS;
      ACCESS:  state_n = RESP;
      default: if (bus.rsp_ready) state_n = IDLE;
    endcase
  end
  always_comb begin
    bus.req_ready = state == IDLE;
    bus.rsp_valid = state == RESP;
    arr_we = state == ACCESS && lat_we;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= 4'd0;
      lat_we <= 1'b0;
      lat_idx <= '0;
      lat_be <= 4'h0;
      lat_wdata <= 32'h0;
      bus.rsp_rdata <= 32'h0;
      bus.rsp_err <= 1'b0;
    end else begin
      if (acc) begin
        lat_we <= bus.req_we;
        lat_idx <= bus.req_addr[AW+1:2];
        lat_be <= bus.req_be;
        lat_wdata <= bus.req_wdata;
        cnt <= 4'(WAIT_CYCLES);
        bus.rsp_err <= bad;
        bus.rsp_rdata <= 32'h0;
      end
      if (state == WAIT) cnt <= cnt - 4'd1;
      if (state == ACCESS) bus.rsp_rdata <= lat_we ? 32'h0 : arr_rdata;
      if (bus.rsp_valid && bus.rsp_ready) begin
        bus.rsp_rdata <= 32'h0;
        bus.rsp_err <= 1'b0;
      end
    end
  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk(clk), .we(arr_we), .be(lat_be), .idx(lat_idx), .wdata(lat_wdata), .rdata(arr_rdata)
  );
endmodule
